// File: rtl/input_debounce_counter_if.sv
// Signal bundle between the raw-input source and the debounce/event-count block.
interface input_debounce_counter_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 din;
    logic                 cnt_en;
    logic                 cnt_clr;
    logic                 dout;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] count;
    logic                 count_wrap;

    modport master (
        output din, cnt_en, cnt_clr,
        input  dout, rise, fall, count, count_wrap
    );

    modport slave (
        input  din, cnt_en, cnt_clr,
        output dout, rise, fall, count, count_wrap
    );
endinterface

// File: rtl/input_debounce_counter.sv
// Synchronises and debounces a raw level input, emits rise/fall pulses and
// counts accepted rising edges in a wrapping counter.
module input_debounce_counter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input logic                     clk,
    input logic                     resetn,
    input_debounce_counter_if.slave bus
);

    localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StStableLo,
        StChkHi,
        StStableHi,
        StChkLo
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ds;
    state_e                 state_q;
    logic [DCNT_W-1:0]      dcnt_q;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   count_wrap_q;
    logic                   rise_evt;
    logic                   fall_evt;

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
        end
    end

    assign ds = sync_q[SYNC_STAGES-1];

    assign rise_evt = (state_q == StChkHi) && ds && (dcnt_q == DCNT_LAST);
    assign fall_evt = (state_q == StChkLo) && !ds && (dcnt_q == DCNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StStableLo;
            dcnt_q  <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                StStableLo: begin
                    if (ds) begin
                        state_q <= StChkHi;
                        dcnt_q  <= DCNT_W'(1);
                    end
                end
                StChkHi: begin
                    if (!ds) begin
                        state_q <= StStableLo;
                        dcnt_q  <= '0;
                    end else if (rise_evt) begin
                        state_q <= StStableHi;
                        dcnt_q  <= '0;
                        dout_q  <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q + DCNT_W'(1);
                    end
                end
                StStableHi: begin
                    if (!ds) begin
                        state_q <= StChkLo;
                        dcnt_q  <= DCNT_W'(1);
                    end
                end
                StChkLo: begin
                    if (ds) begin
                        state_q <= StStableHi;
                        dcnt_q  <= '0;
                    end else if (fall_evt) begin
                        state_q <= StStableLo;
                        dcnt_q  <= '0;
                        dout_q  <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q + DCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StStableLo;
                    dcnt_q  <= '0;
                end
            endcase
        end
    end

    // Clear wins over an increment on the same edge and suppresses the wrap pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q      <= '0;
            count_wrap_q <= 1'b0;
        end else begin
            count_wrap_q <= 1'b0;
            if (bus.cnt_clr) begin
                count_q <= '0;
            end else if (rise_evt && bus.cnt_en) begin
                count_q      <= count_q + CNT_WIDTH'(1);
                count_wrap_q <= &count_q;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.count      = count_q;
    assign bus.count_wrap = count_wrap_q;

endmodule

// File: tb/tb_input_debounce_counter.sv
// Scoreboard bench: a per-edge reference model pushes expected outputs, which are
// popped and compared after each clock edge; directed checks cover the corner cases.
module tb_input_debounce_counter;

    localparam int unsigned S = 2;
    localparam int unsigned D = 4;
    localparam int unsigned W = 8;

    typedef struct {
        logic         dout;
        logic         rise;
        logic         fall;
        logic [W-1:0] count;
        logic         wrap;
    } exp_t;

    logic clk;
    logic resetn;

    input_debounce_counter_if #(.CNT_WIDTH(W)) bus ();

    input_debounce_counter #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (W)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int n_rise;
    int n_fall;
    int n_wrap;
    int n_wrap_rise;
    int edge_idx;
    int first_rise_edge;

    exp_t exp_q[$];

    logic [S-1:0] m_sync;
    logic         m_dout;
    int           m_run;
    logic [W-1:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = '0;
        m_dout = 1'b0;
        m_run  = 0;
        m_cnt  = '0;
        exp_q.delete();
    endtask

    // Reference: count consecutive synchronised samples that differ from the accepted level.
    task automatic model_edge(input logic din, input logic en, input logic clr, output exp_t e);
        logic   ds;
        logic [W:0] sum;
        ds     = m_sync[S-1];
        m_sync = {m_sync[S-2:0], din};
        e.rise = 1'b0;
        e.fall = 1'b0;
        e.wrap = 1'b0;
        if (ds != m_dout) begin
            m_run++;
            if (m_run == D) begin
                m_dout = ds;
                m_run  = 0;
                if (ds) e.rise = 1'b1;
                else    e.fall = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        if (clr) begin
            m_cnt = '0;
        end else if (e.rise && en) begin
            sum    = {1'b0, m_cnt} + 1;
            e.wrap = sum[W];
            m_cnt  = sum[W-1:0];
        end
        e.dout  = m_dout;
        e.count = m_cnt;
    endtask

    task automatic step(input logic din, input logic en, input logic clr);
        exp_t e;
        bus.din     = din;
        bus.cnt_en  = en;
        bus.cnt_clr = clr;
        model_edge(din, en, clr, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        edge_idx++;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_dout", 32'(bus.dout), 32'(e.dout));
            check_eq("sb_rise", 32'(bus.rise), 32'(e.rise));
            check_eq("sb_fall", 32'(bus.fall), 32'(e.fall));
            check_eq("sb_count", 32'(bus.count), 32'(e.count));
            check_eq("sb_wrap", 32'(bus.count_wrap), 32'(e.wrap));
        end
        if (bus.rise) begin
            n_rise++;
            if (first_rise_edge == 0) first_rise_edge = edge_idx;
        end
        if (bus.fall) n_fall++;
        if (bus.count_wrap) n_wrap++;
        if (bus.count_wrap && bus.rise) n_wrap_rise++;
    endtask

    task automatic idle(input int n, input logic din);
        for (int i = 0; i < n; i++) step(din, 1'b1, 1'b0);
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic mark();
        edge_idx        = 0;
        first_rise_edge = 0;
        n_rise          = 0;
        n_fall          = 0;
        n_wrap          = 0;
        n_wrap_rise     = 0;
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        bus.din     = 1'b0;
        bus.cnt_en  = 1'b1;
        bus.cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mark();
        do_reset();

        check_eq("rst_dout", 32'(bus.dout), 32'd0);
        check_eq("rst_rise", 32'(bus.rise), 32'd0);
        check_eq("rst_fall", 32'(bus.fall), 32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_wrap", 32'(bus.count_wrap), 32'd0);

        // Step response: first edge sampling din=1 is edge 1.
        idle(3, 1'b0);
        mark();
        idle(10, 1'b1);
        check_eq("step_latency", 32'(first_rise_edge), 32'd6);
        check_eq("step_rises", 32'(n_rise), 32'd1);
        check_eq("step_falls", 32'(n_fall), 32'd0);
        check_eq("step_count", 32'(bus.count), 32'd1);
        check_eq("step_dout", 32'(bus.dout), 32'd1);
        idle(10, 1'b0);

        // Glitch shorter than the window, then exactly the window.
        mark();
        pulse(3, 10);
        check_eq("glitch3_rises", 32'(n_rise), 32'd0);
        check_eq("glitch3_falls", 32'(n_fall), 32'd0);
        check_eq("glitch3_count", 32'(bus.count), 32'd1);
        mark();
        pulse(4, 10);
        check_eq("glitch4_rises", 32'(n_rise), 32'd1);
        check_eq("glitch4_count", 32'(bus.count), 32'd2);

        // Bounce straight after reset.
        do_reset();
        mark();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(8, 1'b1);
        check_eq("bounce_rises", 32'(n_rise), 32'd1);
        check_eq("bounce_edge", 32'(first_rise_edge), 32'd8);
        idle(8, 1'b0);

        // cnt_en low except at the rise edge: only the rise-edge value matters.
        mark();
        for (int i = 0; i < 8; i++) step(1'b1, (i == 5), 1'b0);
        check_eq("en_rise_edge", 32'(first_rise_edge), 32'd6);
        check_eq("en_count", 32'(bus.count), 32'd2);
        idle(8, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, (i != 5), 1'b0);
        check_eq("en_off_count", 32'(bus.count), 32'd2);
        idle(8, 1'b0);

        // Wrap after 256 events.
        step(1'b0, 1'b1, 1'b1);
        mark();
        for (int i = 0; i < 256; i++) pulse(6, 8);
        check_eq("wrap_rises", 32'(n_rise), 32'd256);
        check_eq("wrap_count", 32'(bus.count), 32'd0);
        check_eq("wrap_pulses", 32'(n_wrap), 32'd1);
        check_eq("wrap_with_rise", 32'(n_wrap_rise), 32'd1);

        // Clear coincident with a rise.
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) pulse(6, 8);
        check_eq("clr_pre_count", 32'(bus.count), 32'd5);
        mark();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i == 5));
        check_eq("clr_rise_edge", 32'(first_rise_edge), 32'd6);
        check_eq("clr_count", 32'(bus.count), 32'd0);
        check_eq("clr_wrap", 32'(n_wrap), 32'd0);
        idle(8, 1'b0);
        pulse(6, 8);
        check_eq("clr_next_count", 32'(bus.count), 32'd1);

        // Reset while in the high-check window with count=3.
        pulse(6, 8);
        pulse(6, 8);
        check_eq("rstmid_pre_count", 32'(bus.count), 32'd3);
        idle(4, 1'b1);
        resetn = 1'b0;
        #1;
        check_eq("rstmid_dout", 32'(bus.dout), 32'd0);
        check_eq("rstmid_rise", 32'(bus.rise), 32'd0);
        check_eq("rstmid_count", 32'(bus.count), 32'd0);
        check_eq("rstmid_wrap", 32'(bus.count_wrap), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rstmid_held_rise", 32'(bus.rise), 32'd0);
        resetn = 1'b1;
        mark();
        idle(10, 1'b1);
        check_eq("rstmid_latency", 32'(first_rise_edge), 32'd6);
        check_eq("rstmid_rises", 32'(n_rise), 32'd1);
        check_eq("rstmid_count_after", 32'(bus.count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
